avl_req_arbiter: RTL and testbench

- Shares one Avalon-MM master port between N_REQ independent requesters, e.g. instruction fetch, data load/store and a debug/DMA port.
- Arbitrates between requesters, then runs one non-pipelined Avalon transfer at a time and returns read data to the winner with a one-cycle done pulse.
- Includes a waitrequest watchdog so a hung slave cannot stall the CPU indefinitely.
- Sits between the CPU memory ports and the system interconnect, in place of a fixed-priority Harvard mux.

---
 rtl/avl_pkg.sv | 7 +
 rtl/rr_pick.sv | 24 ++
 rtl/avl_req_arbiter.sv | 87 ++++++++
 tb/tb_avl_req_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/avl_pkg.sv
// avl_pkg: shared state type and Avalon widths for the request arbiter
package avl_pkg;
  localparam int AVL_AW = 32;
  localparam int AVL_DW = 32;
  localparam int AVL_BEW = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin / fixed-priority winner select
module rr_pick #(
  parameter int N = 2,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] winner,
  output logic          any_valid
);
  logic [IW-1:0] idx;
  // Fixed priority is round-robin that always restarts after index N-1.
  // Scanning from the far end lets the nearest valid index overwrite the rest.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'(((FIXED_PRIO ? N - 1 : int'(last_grant)) + k) % N);
      if (valid[idx]) winner = idx;
    end
  end
  assign any_valid = |valid;
endmodule

// File: rtl/avl_req_arbiter.sv
// avl_req_arbiter: shares one non-pipelined Avalon-MM master between N_REQ requesters,
// with a waitrequest watchdog that aborts hung transfers.
module avl_req_arbiter
  import avl_pkg::*;
#(
  parameter int          N_REQ      = 2,
  parameter int          FIXED_PRIO = 0,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_read,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*AVL_AW-1:0]    req_address,
  input  logic [N_REQ*AVL_DW-1:0]    req_writedata,
  input  logic [N_REQ*AVL_BEW-1:0]   req_byteenable,
  output logic [AVL_DW-1:0]          req_readdata,
  output logic [N_REQ-1:0]           req_done,
  output logic [N_REQ-1:0]           req_err,
  output logic [AVL_AW-1:0]          avl_address,
  output logic [AVL_BEW-1:0]         avl_byteenable,
  output logic [AVL_DW-1:0]          avl_writedata,
  output logic                       avl_read,
  output logic                       avl_write,
  input  logic [AVL_DW-1:0]          avl_readdata,
  input  logic                       avl_waitrequest
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  arb_state_t state, state_nxt;
  logic [IW-1:0] grant, last_grant, winner;
  logic [CW-1:0] cnt;
  logic any_valid, fin;
  rr_pick #(.N(N_REQ), .FIXED_PRIO(FIXED_PRIO != 0)) u_pick (
    .valid(req_read ^ req_write),
    .last_grant(last_grant),
    .winner(winner),
    .any_valid(any_valid)
  );
  // A zero waitrequest wins over the watchdog when both land on the same cycle.
  assign fin = !avl_waitrequest || cnt == CW'(TIMEOUT - 1);
  always_comb
    state_nxt = (state == IDLE) ? (any_valid ? BUSY : IDLE) :
                (state == BUSY) ? (fin ? DONE : BUSY) : IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      avl_read <= 1'b0;
      avl_write <= 1'b0;
      avl_address <= '0;
      avl_writedata <= '0;
      avl_byteenable <= '1;
      req_readdata <= '0;
      req_done <= '0;
      req_err <= '0;
      grant <= '0;
      last_grant <= IW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      state <= state_nxt;
      req_done <= '0;
      req_err <= '0;
      if (state == IDLE && any_valid) begin
        avl_address <= req_address[AVL_AW*int'(winner) +: AVL_AW];
        avl_writedata <= req_writedata[AVL_DW*int'(winner) +: AVL_DW];
        avl_byteenable <= req_byteenable[AVL_BEW*int'(winner) +: AVL_BEW];
        avl_read <= req_read[winner];
        avl_write <= req_write[winner];
        grant <= winner;
        last_grant <= winner;
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        if (fin) begin
          avl_read <= 1'b0;
          avl_write <= 1'b0;
          req_done[grant] <= 1'b1;
          req_err[grant] <= avl_waitrequest;
          if (avl_waitrequest) req_readdata <= ERR_DATA;
          else if (avl_read) req_readdata <= avl_readdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_avl_req_arbiter.sv
// tb_avl_req_arbiter: directed checks of a round-robin and a fixed-priority arbiter
module tb_avl_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] rd, wr;
  logic [63:0] addr, wd;
  logic [7:0] be;
  logic [31:0] rdata;
  logic wreq;
  logic [31:0] rdd, a_addr, a_wd, rdd_f, a_addr_f, a_wd_f;
  logic [1:0] done, err, done_f, err_f;
  logic [3:0] a_be, a_be_f;
  logic a_rd, a_wr, a_rd_f, a_wr_f;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avl_req_arbiter #(.N_REQ(2), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_read(rd), .req_write(wr), .req_address(addr),
    .req_writedata(wd), .req_byteenable(be), .req_readdata(rdd), .req_done(done),
    .req_err(err), .avl_address(a_addr), .avl_byteenable(a_be), .avl_writedata(a_wd),
    .avl_read(a_rd), .avl_write(a_wr), .avl_readdata(rdata), .avl_waitrequest(wreq)
  );

  avl_req_arbiter #(.N_REQ(2), .FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_read(rd), .req_write(wr), .req_address(addr),
    .req_writedata(wd), .req_byteenable(be), .req_readdata(rdd_f), .req_done(done_f),
    .req_err(err_f), .avl_address(a_addr_f), .avl_byteenable(a_be_f), .avl_writedata(a_wd_f),
    .avl_read(a_rd_f), .avl_write(a_wr_f), .avl_readdata(rdata), .avl_waitrequest(wreq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    n_cmp++; if ({a_rd, a_wr} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {a_rd, a_wr}); end
    n_cmp++; if (a_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", a_addr); end
    n_cmp++; if (a_be !== 4'hF) begin n_bad++; $display("FAIL reset_be: got %h want f", a_be); end
    n_cmp++; if (rdd !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdd); end
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b want 00", done); end
    n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    addr[31:0] = 32'h100;
    rdata = 32'h12345678;
    rd = 2'b01;
    wreq = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      n_cmp++; if (a_rd !== 1'b1 || a_addr !== 32'h100) begin n_bad++; $display("FAIL read_busy c%0d: got rd=%b addr=%h want rd=1 addr=100", c, a_rd, a_addr); end
      if (c == 3) wreq = 1'b0;
    end
    cyc();
    n_cmp++; if (a_rd !== 1'b0) begin n_bad++; $display("FAIL read_drop: got %b want 0", a_rd); end
    n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL read_done: got %b want 01", done); end
    n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL read_err: got %b want 00", err); end
    n_cmp++; if (rdd !== 32'h12345678) begin n_bad++; $display("FAIL read_data: got %h want 12345678", rdd); end
    rd = 2'b00;
    wreq = 1'b1;
    cyc();
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL read_done_clear: got %b want 00", done); end
  endtask

  task automatic test_write_be();
    wr = 2'b10;
    addr[63:32] = 32'h2000;
    wd[63:32] = 32'hCAFEF00D;
    be[7:4] = 4'b0011;
    cyc();
    n_cmp++; if ({a_rd, a_wr} !== 2'b01) begin n_bad++; $display("FAIL wr_strobes: got %b want 01", {a_rd, a_wr}); end
    n_cmp++; if (a_be !== 4'b0011) begin n_bad++; $display("FAIL wr_be: got %b want 0011", a_be); end
    n_cmp++; if (a_addr !== 32'h2000 || a_wd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wr_addr_data: got %h/%h want 2000/cafef00d", a_addr, a_wd); end
    be[7:4] = 4'hF;
    addr[63:32] = 32'hFFFF0000;
    cyc();
    n_cmp++; if (a_be !== 4'b0011 || a_addr !== 32'h2000 || a_wr !== 1'b1) begin n_bad++; $display("FAIL wr_hold: got be=%b addr=%h wr=%b want 0011/2000/1", a_be, a_addr, a_wr); end
    wreq = 1'b0;
    cyc();
    n_cmp++; if (done !== 2'b10) begin n_bad++; $display("FAIL wr_done: got %b want 10", done); end
    n_cmp++; if (rdd !== 32'h12345678) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want 12345678", rdd); end
    n_cmp++; if (a_wr !== 1'b0 || err !== 2'b00) begin n_bad++; $display("FAIL wr_drop: got wr=%b err=%b want 0/00", a_wr, err); end
    wr = 2'b00;
    cyc();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rd = 2'b11;
    wreq = 1'b0;
    rdata = 32'h0BADF00D;
    for (int c = 1; c <= 12; c++) begin
      logic [1:0] exp;
      cyc();
      exp = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_cmp++; if (done !== exp) begin n_bad++; $display("FAIL rr_done c%0d: got %b want %b", c, done, exp); end
      n_cmp++; if (a_rd && a_wr) begin n_bad++; $display("FAIL rr_strobes c%0d: got rd=%b wr=%b want not both", c, a_rd, a_wr); end
    end
    rd = 2'b00;
    repeat (2) cyc();
  endtask

  task automatic test_fixed_prio();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rd = 2'b11;
    for (int c = 1; c <= 14; c++) begin
      logic [1:0] exp;
      cyc();
      exp = (c % 3 == 2) ? ((c > 11) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++; if (done_f !== exp) begin n_bad++; $display("FAIL fp_done c%0d: got %b want %b", c, done_f, exp); end
      if (c == 11) rd = 2'b10;
    end
    rd = 2'b00;
    repeat (2) cyc();
  endtask

  task automatic test_timeout();
    rd = 2'b01;
    addr[31:0] = 32'h300;
    wreq = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      n_cmp++; if (a_rd !== 1'b1) begin n_bad++; $display("FAIL to_busy c%0d: got %b want 1", c, a_rd); end
    end
    cyc();
    n_cmp++; if (a_rd !== 1'b0) begin n_bad++; $display("FAIL to_drop: got %b want 0", a_rd); end
    n_cmp++; if (done !== 2'b01 || err !== 2'b01) begin n_bad++; $display("FAIL to_flags: got done=%b err=%b want 01/01", done, err); end
    n_cmp++; if (rdd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL to_data: got %h want deadbeef", rdd); end
    rd = 2'b00;
    cyc();
    n_cmp++; if (done !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL to_clear: got done=%b err=%b want 00/00", done, err); end
    rd = 2'b01;
    wreq = 1'b0;
    rdata = 32'hA5A50001;
    repeat (2) cyc();
    n_cmp++; if (done !== 2'b01 || err !== 2'b00 || rdd !== 32'hA5A50001) begin n_bad++; $display("FAIL to_recover: got done=%b err=%b data=%h want 01/00/a5a50001", done, err, rdd); end
    rd = 2'b00;
    cyc();
  endtask

  task automatic test_illegal_reset();
    rd = 2'b01;
    wr = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      n_cmp++; if ({a_rd, a_wr} !== 2'b00 || done !== 2'b00) begin n_bad++; $display("FAIL illegal c%0d: got strobes=%b done=%b want 00/00", c, {a_rd, a_wr}, done); end
    end
    wr = 2'b00;
    addr = {32'h500, 32'h400};
    wreq = 1'b1;
    cyc();
    n_cmp++; if (a_rd !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 1", a_rd); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_rd !== 1'b0) begin n_bad++; $display("FAIL async_reset_rd: got %b want 0", a_rd); end
    cyc();
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL reset_no_done: got %b want 00", done); end
    rst_n = 1'b1;
    rd = 2'b11;
    wreq = 1'b0;
    cyc();
    n_cmp++; if (a_rd !== 1'b1 || a_addr !== 32'h400) begin n_bad++; $display("FAIL post_reset_grant: got rd=%b addr=%h want 1/400", a_rd, a_addr); end
    cyc();
    n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL post_reset_done: got %b want 01", done); end
    rd = 2'b00;
    cyc();
  endtask

  initial begin
    rd = '0;
    wr = '0;
    addr = '0;
    wd = '0;
    be = '1;
    rdata = '0;
    wreq = 1'b1;
    test_reset();
    test_single_read();
    test_write_be();
    test_round_robin();
    test_fixed_prio();
    test_timeout();
    test_illegal_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
